game_session_controller: RTL and testbench

Top-level game session sequencer that sits upstream of the collision/score logic. It debounces the board buttons, runs the mode/difficulty menu, and arms the game after a start delay by asserting `game_active`. It then tears the session down when the logic block raises `return_to_menu`. It is the initiator end of the `game_active` / `return_to_menu` handshake.

---
 rtl/game_session_controller.sv | 134 +++++++++++++
 tb/tb_game_session_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/game_session_controller.sv
// rtl/game_session_controller.sv - button debounce, menu FSM and game arming for the game session
module game_session_controller #(
  parameter int DEBOUNCE_CYCLES    = 2_000_000,
  parameter int START_DELAY_CYCLES = 100_000_000
) (
  input  logic       clock_100mhz,
  input  logic       reset_n,
  input  logic       btnC,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       return_to_menu,
  output logic       game_active,
  output logic       mode,
  output logic       difficulty,
  output logic [1:0] menu_page,
  output logic [7:0] session_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = (START_DELAY_CYCLES > 1) ? $clog2(START_DELAY_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DELAY_LOAD = DW'(START_DELAY_CYCLES - 1);

  typedef enum logic [2:0] {S_MODE, S_DIFF, S_ARM, S_PLAY, S_EXIT} state_t;

  // Button index: 0 = centre, 1 = up, 2 = down
  logic [2:0]    raw, sync1, sync2, stable, stable_d, press;
  logic [CW-1:0] deb_cnt [3];

  assign raw = {btnD, btnU, btnC};

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      press    <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        state, state_next;
  logic [DW-1:0] delay, delay_next;
  logic          mode_next, diff_next, toggle;
  logic [7:0]    count_next;
  logic [1:0]    page_next;

  assign toggle = press[1] ^ press[2];

  always_comb begin
    state_next = state;
    delay_next = delay;
    mode_next  = mode;
    diff_next  = difficulty;
    count_next = session_count;
    case (state)
      S_MODE: begin
        if (press[0])    state_next = S_DIFF;
        else if (toggle) mode_next  = ~mode;
      end
      S_DIFF: begin
        if (press[0]) begin
          state_next = S_ARM;
          delay_next = DELAY_LOAD;
        end else if (toggle) begin
          diff_next = ~difficulty;
        end
      end
      S_ARM: begin
        if (delay == '0) begin
          state_next = S_PLAY;
          count_next = session_count + 8'd1;
        end else begin
          delay_next = delay - 1'b1;
        end
      end
      S_PLAY: begin
        if (return_to_menu) state_next = S_EXIT;
      end
      S_EXIT: begin
        // Wait for the dismissing centre press to be released before re-entering the menu
        if (!return_to_menu && !stable[0]) state_next = S_MODE;
      end
      default: state_next = S_MODE;
    endcase
  end

  always_comb begin
    page_next = 2'd3;
    case (state_next)
      S_MODE:  page_next = 2'd0;
      S_DIFF:  page_next = 2'd1;
      S_ARM:   page_next = 2'd2;
      default: page_next = 2'd3;
    endcase
  end

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_MODE;
      delay         <= '0;
      mode          <= 1'b0;
      difficulty    <= 1'b0;
      session_count <= 8'd0;
      game_active   <= 1'b0;
      menu_page     <= 2'd0;
    end else begin
      state         <= state_next;
      delay         <= delay_next;
      mode          <= mode_next;
      difficulty    <= diff_next;
      session_count <= count_next;
      game_active   <= (state_next == S_PLAY);
      menu_page     <= page_next;
    end
  end

endmodule

// File: tb/tb_game_session_controller.sv
// tb/tb_game_session_controller.sv - directed self-checking bench for game_session_controller
module tb_game_session_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btnC = 1'b0, btnU = 1'b0, btnD = 1'b0, rtm = 1'b0;
  logic       game_active, mode, difficulty;
  logic [1:0] menu_page;
  logic [7:0] session_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_session_controller #(.DEBOUNCE_CYCLES(4), .START_DELAY_CYCLES(10)) dut (
    .clock_100mhz  (clk),
    .reset_n       (reset_n),
    .btnC          (btnC),
    .btnU          (btnU),
    .btnD          (btnD),
    .return_to_menu(rtm),
    .game_active   (game_active),
    .mode          (mode),
    .difficulty    (difficulty),
    .menu_page     (menu_page),
    .session_count (session_count)
  );

  typedef struct {
    logic       c, u, d, r;
    int         hold;
    logic       e_mode, e_diff;
    logic [1:0] e_page;
    logic       e_act;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs [27];

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    btnC = 0; btnU = 0; btnD = 0; rtm = 0;
    reset_n = 0;
    step(2);
    reset_n = 1;
    step(1);
  endtask

  task automatic press_c();
    btnC = 1; step(8);
    btnC = 0; step(8);
  endtask

  task automatic session(input string tag);
    press_c();
    press_c();
    for (int i = 0; i < 20 && !game_active; i++) step(1);
    chk({tag, "_reach_play"}, game_active, 1);
    rtm = 1; step(1);
    rtm = 0; step(1);
  endtask

  initial begin
    //            c  u  d  r  hold mode diff page act cnt
    vecs[0]  = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 8, 1, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 8, 1, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 0, 8, 1, 0, 1, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 8, 1, 0, 1, 0, 0};
    vecs[5]  = '{0, 0, 1, 0, 8, 1, 1, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 8, 1, 1, 1, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 8, 1, 1, 2, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 9, 1, 1, 2, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 1, 1, 1, 3, 1, 1};
    vecs[10] = '{1, 0, 0, 0, 8, 1, 1, 3, 1, 1};
    vecs[11] = '{1, 0, 0, 1, 1, 1, 1, 3, 0, 1};
    vecs[12] = '{1, 0, 0, 0, 10, 1, 1, 3, 0, 1};
    vecs[13] = '{0, 0, 0, 0, 6, 1, 1, 3, 0, 1};
    vecs[14] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 1};
    vecs[15] = '{1, 1, 0, 0, 8, 1, 1, 1, 0, 1};
    vecs[16] = '{0, 0, 0, 0, 8, 1, 1, 1, 0, 1};
    vecs[17] = '{0, 1, 1, 0, 8, 1, 1, 1, 0, 1};
    vecs[18] = '{0, 0, 0, 0, 8, 1, 1, 1, 0, 1};
    vecs[19] = '{1, 0, 0, 0, 8, 1, 1, 2, 0, 1};
    vecs[20] = '{0, 1, 0, 0, 8, 1, 1, 2, 0, 1};
    vecs[21] = '{0, 0, 0, 0, 1, 1, 1, 2, 0, 1};
    vecs[22] = '{0, 0, 0, 0, 1, 1, 1, 3, 1, 2};
    vecs[23] = '{0, 0, 0, 1, 1, 1, 1, 3, 0, 2};
    vecs[24] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 2};
    vecs[25] = '{0, 0, 0, 1, 3, 1, 1, 0, 0, 2};
    vecs[26] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 2};

    do_reset();
    chk("rst_active", game_active, 0);
    chk("rst_mode", mode, 0);
    chk("rst_diff", difficulty, 0);
    chk("rst_page", menu_page, 0);
    chk("rst_count", session_count, 0);

    // Short glitch on up must not toggle; held press toggles exactly once at k+7
    btnU = 1; step(3);
    btnU = 0; step(8);
    chk("glitch_mode", mode, 0);
    btnU = 1; step(7);
    chk("deb_early_mode", mode, 0);
    step(1);
    chk("deb_edge_mode", mode, 1);
    step(12);
    btnU = 0; step(10);
    chk("deb_once_mode", mode, 1);

    do_reset();
    for (int i = 0; i < 27; i++) begin
      btnC = vecs[i].c; btnU = vecs[i].u; btnD = vecs[i].d; rtm = vecs[i].r;
      step(vecs[i].hold);
      chk($sformatf("vec%0d_mode", i), mode, vecs[i].e_mode);
      chk($sformatf("vec%0d_diff", i), difficulty, vecs[i].e_diff);
      chk($sformatf("vec%0d_page", i), menu_page, vecs[i].e_page);
      chk($sformatf("vec%0d_active", i), game_active, vecs[i].e_act);
      chk($sformatf("vec%0d_count", i), session_count, vecs[i].e_cnt);
    end

    // Asynchronous reset in the middle of a game, between clock edges
    press_c();
    press_c();
    for (int i = 0; i < 20 && !game_active; i++) step(1);
    chk("arst_in_play", game_active, 1);
    #2 reset_n = 0;
    #1;
    chk("arst_active_now", game_active, 0);
    chk("arst_page_now", menu_page, 0);
    chk("arst_count_now", session_count, 0);
    #3 reset_n = 1;
    step(2);
    chk("arst_mode", mode, 0);
    chk("arst_diff", difficulty, 0);
    chk("arst_page", menu_page, 0);
    chk("arst_active", game_active, 0);
    chk("arst_count", session_count, 0);

    // Session counter wrap
    do_reset();
    for (int s = 0; s < 255; s++) session($sformatf("s%0d", s));
    chk("wrap_255", session_count, 255);
    chk("wrap_page_mode", menu_page, 0);
    session("s255");
    chk("wrap_0", session_count, 0);

    rtm = 1; step(3);
    chk("rtm_menu_page", menu_page, 0);
    chk("rtm_menu_active", game_active, 0);
    rtm = 0; step(1);
    chk("rtm_menu_page_after", menu_page, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
